// File: rtl/line_raster.sv
// line_raster: Bresenham walk from endpoint 1 to endpoint 2, emitting one
// on-screen pixel per handshake and silently skipping off-screen pixels.
module line_raster #(
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seg_valid,
  output logic               seg_ready,
  input  logic [9:0]         x1,
  input  logic [9:0]         y1,
  input  logic [9:0]         x2,
  input  logic [9:0]         y2,
  input  logic [COLOR_W-1:0] seg_color,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [9:0]         pix_x,
  output logic [9:0]         pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_last,
  output logic               seg_done,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

  localparam logic [9:0] X_LIM = 10'(X_MAX);
  localparam logic [9:0] Y_LIM = 10'(Y_MAX);

  state_t state, state_next;

  logic [9:0]         cur_x, cur_y, end_x, end_y;
  logic [COLOR_W-1:0] color_q;
  logic signed [11:0] dx, dy, err;
  logic               step_x_neg, step_y_neg;
  logic               seg_done_q;

  logic               on_screen, at_end, advance;
  logic [9:0]         abs_dx, abs_dy;
  logic signed [11:0] setup_dx, setup_dy;
  logic signed [12:0] e2, dx13, dy13;
  logic               step_x, step_y;
  logic signed [11:0] err_next;

  // The walk terminates exactly on endpoint 2, so cur never leaves the
  // bounding box and the 10-bit coordinates cannot wrap.
  assign on_screen = (cur_x <= X_LIM) && (cur_y <= Y_LIM);
  assign at_end    = (cur_x == end_x) && (cur_y == end_y);
  assign advance   = (state == DRAW) && (!on_screen || pix_ready);

  // In SETUP cur still holds endpoint 1, so the deltas come from cur vs end.
  assign abs_dx   = (cur_x < end_x) ? (end_x - cur_x) : (cur_x - end_x);
  assign abs_dy   = (cur_y < end_y) ? (end_y - cur_y) : (cur_y - end_y);
  assign setup_dx = $signed({2'b00, abs_dx});
  assign setup_dy = -$signed({2'b00, abs_dy});

  // Error doubled into 13 bits so 2*err never overflows.
  assign e2       = {err, 1'b0};
  assign dx13     = {dx[11], dx};
  assign dy13     = {dy[11], dy};
  assign step_x   = (e2 >= dy13);
  assign step_y   = (e2 <= dx13);
  assign err_next = err + (step_x ? dy : 12'sd0) + (step_y ? dx : 12'sd0);

  assign seg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign pix_valid = (state == DRAW) && on_screen;
  assign pix_last  = pix_valid && at_end;
  assign pix_x     = cur_x;
  assign pix_y     = cur_y;
  assign pix_color = color_q;
  assign seg_done  = seg_done_q;

  // State register; reset aborts any segment in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: one SETUP cycle, then DRAW until endpoint 2 is consumed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (seg_valid) state_next = SETUP;
      SETUP:   state_next = DRAW;
      DRAW:    if (advance && at_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch command, derive Bresenham terms, then step the walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x      <= '0;
      cur_y      <= '0;
      end_x      <= '0;
      end_y      <= '0;
      color_q    <= '0;
      dx         <= '0;
      dy         <= '0;
      err        <= '0;
      step_x_neg <= 1'b0;
      step_y_neg <= 1'b0;
      seg_done_q <= 1'b0;
    end else begin
      seg_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (seg_valid) begin
            cur_x   <= x1;
            cur_y   <= y1;
            end_x   <= x2;
            end_y   <= y2;
            color_q <= seg_color;
          end
        end
        SETUP: begin
          dx         <= setup_dx;
          dy         <= setup_dy;
          err        <= setup_dx + setup_dy;
          step_x_neg <= !(cur_x < end_x);
          step_y_neg <= !(cur_y < end_y);
        end
        DRAW: begin
          if (advance) begin
            if (at_end) begin
              seg_done_q <= 1'b1;
            end else begin
              err <= err_next;
              if (step_x) cur_x <= step_x_neg ? (cur_x - 10'd1) : (cur_x + 10'd1);
              if (step_y) cur_y <= step_y_neg ? (cur_y - 10'd1) : (cur_y + 10'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_raster.sv
// tb_line_raster: directed checks of line_raster with hand-computed pixel walks.
module tb_line_raster;

  logic       clk = 1'b0;
  logic       rst;
  logic       seg_valid;
  logic       seg_ready;
  logic [9:0] x1, y1, x2, y2;
  logic [7:0] seg_color;
  logic       pix_valid;
  logic       pix_ready;
  logic [9:0] pix_x, pix_y;
  logic [7:0] pix_color;
  logic       pix_last;
  logic       seg_done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  line_raster #(.X_MAX(639), .Y_MAX(479), .COLOR_W(8)) dut (
    .clk(clk), .rst(rst),
    .seg_valid(seg_valid), .seg_ready(seg_ready),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .seg_color(seg_color),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_last(pix_last),
    .seg_done(seg_done), .busy(busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one command for one edge; afterwards we sit in the SETUP cycle.
  task automatic applyStimulus(input logic [9:0] ax1, input logic [9:0] ay1,
                               input logic [9:0] ax2, input logic [9:0] ay2,
                               input logic [7:0] col);
    x1 = ax1; y1 = ay1; x2 = ax2; y2 = ay2; seg_color = col;
    seg_valid = 1'b1;
    checkOutput("seg_ready_before_accept", 32'(seg_ready), 32'd1);
    tick();
    seg_valid = 1'b0;
    checkOutput("setup_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("setup_busy", 32'(busy), 32'd1);
    checkOutput("setup_seg_ready", 32'(seg_ready), 32'd0);
    tick();
  endtask

  task automatic checkBeat(input string tag, input int ex, input int ey, input logic last);
    checkOutput({tag, "_valid"}, 32'(pix_valid), 32'd1);
    checkOutput({tag, "_x"}, 32'(pix_x), 32'(ex));
    checkOutput({tag, "_y"}, 32'(pix_y), 32'(ey));
    checkOutput({tag, "_last"}, 32'(pix_last), 32'(last));
    checkOutput({tag, "_done_low"}, 32'(seg_done), 32'd0);
  endtask

  initial begin
    int steep_x [5] = '{2, 1, 1, 0, 0};
    int steep_y [5] = '{4, 3, 2, 1, 0};
    int beats;

    rst = 1'b1; seg_valid = 1'b1; pix_ready = 1'b1;
    x1 = 10'd5; y1 = 10'd5; x2 = 10'd6; y2 = 10'd6; seg_color = 8'h00;
    tick(); tick();
    // Reset values, with seg_valid high being ignored.
    checkOutput("rst_seg_ready", 32'(seg_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_pix_x", 32'(pix_x), 32'd0);
    checkOutput("rst_pix_y", 32'(pix_y), 32'd0);
    checkOutput("rst_pix_color", 32'(pix_color), 32'd0);
    checkOutput("rst_pix_last", 32'(pix_last), 32'd0);
    checkOutput("rst_seg_done", 32'(seg_done), 32'd0);
    seg_valid = 1'b0;
    rst = 1'b0;
    tick();
    checkOutput("post_rst_idle", 32'(busy), 32'd0);

    // Horizontal line (0,5)->(3,5).
    applyStimulus(10'd0, 10'd5, 10'd3, 10'd5, 8'h11);
    for (int i = 0; i < 4; i++) begin
      checkBeat("horiz", i, 5, (i == 3));
      checkOutput("horiz_color", 32'(pix_color), 32'h11);
      tick();
    end
    checkOutput("horiz_seg_done", 32'(seg_done), 32'd1);
    checkOutput("horiz_seg_ready", 32'(seg_ready), 32'd1);
    checkOutput("horiz_pix_valid_off", 32'(pix_valid), 32'd0);
    tick();
    checkOutput("horiz_seg_done_pulse", 32'(seg_done), 32'd0);

    // Steep reversed line (2,4)->(0,0).
    applyStimulus(10'd2, 10'd4, 10'd0, 10'd0, 8'h22);
    for (int i = 0; i < 5; i++) begin
      checkBeat("steep", steep_x[i], steep_y[i], (i == 4));
      tick();
    end
    checkOutput("steep_seg_done", 32'(seg_done), 32'd1);
    tick();

    // Single point with colour 0xA5.
    applyStimulus(10'd7, 10'd9, 10'd7, 10'd9, 8'hA5);
    checkBeat("point", 7, 9, 1'b1);
    checkOutput("point_color", 32'(pix_color), 32'hA5);
    tick();
    checkOutput("point_busy", 32'(busy), 32'd0);
    checkOutput("point_seg_done", 32'(seg_done), 32'd1);
    tick();

    // Back-pressure on the second pixel of (0,0)->(3,3).
    applyStimulus(10'd0, 10'd0, 10'd3, 10'd3, 8'h33);
    checkBeat("bp0", 0, 0, 1'b0);
    tick();
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkBeat("bp_hold", 1, 1, 1'b0);
      checkOutput("bp_hold_color", 32'(pix_color), 32'h33);
      tick();
    end
    pix_ready = 1'b1;
    checkBeat("bp1", 1, 1, 1'b0);
    tick();
    checkBeat("bp2", 2, 2, 1'b0);
    tick();
    checkBeat("bp3", 3, 3, 1'b1);
    tick();
    checkOutput("bp_seg_done", 32'(seg_done), 32'd1);
    tick();

    // Clipping at x=639: (637,10)->(642,10).
    applyStimulus(10'd637, 10'd10, 10'd642, 10'd10, 8'h44);
    for (int i = 0; i < 3; i++) begin
      checkBeat("clip", 637 + i, 10, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput("clip_skip_valid", 32'(pix_valid), 32'd0);
      checkOutput("clip_skip_last", 32'(pix_last), 32'd0);
      checkOutput("clip_skip_busy", 32'(busy), 32'd1);
      checkOutput("clip_skip_done", 32'(seg_done), 32'd0);
      tick();
    end
    checkOutput("clip_seg_done", 32'(seg_done), 32'd1);
    checkOutput("clip_seg_ready", 32'(seg_ready), 32'd1);
    tick();

    // Reset during the 3rd pixel of (0,0)->(9,0).
    applyStimulus(10'd0, 10'd0, 10'd9, 10'd0, 8'h55);
    tick();
    tick();
    checkBeat("mid_third", 2, 0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("mid_rst_pix_x", 32'(pix_x), 32'd0);
    checkOutput("mid_rst_pix_color", 32'(pix_color), 32'd0);
    checkOutput("mid_rst_seg_ready", 32'(seg_ready), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_seg_done", 32'(seg_done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("after_rst_seg_ready", 32'(seg_ready), 32'd1);
    checkOutput("after_rst_seg_done", 32'(seg_done), 32'd0);

    // Fresh (0,0)->(1,0) must emit exactly two beats before seg_done.
    applyStimulus(10'd0, 10'd0, 10'd1, 10'd0, 8'h66);
    beats = 0;
    for (int i = 0; i < 20 && !seg_done; i++) begin
      if (pix_valid) begin
        checkBeat("fresh", beats, 0, (beats == 1));
        beats++;
      end
      tick();
    end
    checkOutput("fresh_seg_done", 32'(seg_done), 32'd1);
    checkOutput("fresh_beats", 32'(beats), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
